io_ctrl: RTL and testbench
==========================

# io_ctrl

Input/output port controller for the single-cycle CPU. It sits directly downstream of the datapath: it consumes the register-file read value and port number of OUT instructions, and produces the 8-bit value written back by IN instructions into the write-data selection of the register bank. It holds the pipeline through a stall line while a port cannot accept or supply data. Externally it exposes four output channels and four input channels, each with a valid/ready handshake.

## Interface
Parameters:
- NPORTS, 4: number of input channels and number of output channels. Fixed at 4 because the address field is 2 bits.
- W, 8: data width, matching the register bank.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- port_addr  in  2  channel selected by the current IN/OUT instruction.
- wr_en  in  1  OUT instruction active this cycle.
- rd_en  in  1  IN instruction active this cycle. Never asserted together with wr_en.
- wr_data  in  8  value to send. This is the register-file read port 1 value.
- rd_data  out  8  value for register write-back. Combinational.
- stall  out  1  combinational. The control unit must hold the PC and suppress we3 while this is high.
- out_data  out  32  channel i occupies bits [8i+7:8i].
- out_valid  out  4  channel i holds data for the external device.
- out_ready  in  4  external device accepts channel i data.
- in_data  in  32  channel i occupies bits [8i+7:8i].
- in_valid  in  4  external device offers data on channel i.
- in_ready  out  4  channel i can capture data.

## Operation
Output channel i:
- A transfer occurs on any edge where out_valid[i] and out_ready[i] are both high.
- Writes are accepted when wr_en=1, port_addr=i and the channel is not full.
- In 1-entry mode, a write to a full channel is also accepted when out_ready[i]=1 in that same cycle (pass-through). The old word leaves, the new word loads, and the channel stays full.
- In 1-entry mode, stall = wr_en & sel & full & ~out_ready[i].
- out_valid[i] = full flag. out_data holds the head word and is stable while out_valid[i]=1 and out_ready[i]=0.

Input channel i:
- Has a 1-entry holding register and a full flag.
- in_ready[i] = ~full.
- The holding register captures in_data on an edge where in_valid[i]=1 and in_ready[i]=1.
- IN with port_addr=i and full=1: rd_data = held word, and full clears at the edge.
- IN with full=0: rd_data = 8'h00 and stall=1. The instruction repeats each cycle until data is captured; the read completes on the first cycle after capture.
- When rd_en=0, rd_data = 8'h00.

Unselected channels are unaffected by wr_en and rd_en.

Reset (asynchronous, immediate):
- out_valid = 0, out_data = 0, all output FIFOs empty.
- Input full flags = 0, so in_ready = 4'b1111 while reset is held.
- stall = 0 during reset.

Asserting reset in the middle of a handshake discards all pending words.

## Timing
- OUT at edge N: out_valid rises after edge N, so a transfer is possible at edge N+1 at the earliest.
- IN: capture at edge N, data readable in cycle N+1, and in_ready re-rises after the consuming edge.
- Zero-latency combinational paths: rd_data and stall from inputs. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Back-to-back OUT instructions to the same channel with out_ready held high: one word per cycle, no stall.

## Configuration
- IO_OUT_FIFO_EN defined: each output channel has a 4-deep FIFO with a 3-bit count.
  - The write pointer and read pointer wrap modulo 4.
  - Simultaneous write and transfer keep the count unchanged.
  - stall = wr_en & sel & (count==4) & ~out_ready[i].
  - out_valid = (count != 0).
- IO_OUT_FIFO_EN undefined: 1-entry holding register per output channel, exactly as described above.

## Test plan
- Reset then idle: out_valid=0, out_data=0, in_ready=4'hF, stall=0, rd_data=0.
- OUT 8'hA5 to channel 2 with out_ready=0: out_valid=4'b0100 and out_data[23:16]=A5 on the next cycle. A second OUT to channel 2 gives stall=1. Raising out_ready[2] gives stall=0 and out_data becomes the second word.
- IN from channel 1 while empty: stall=1 and rd_data=0. Drive in_valid[1] with 8'h3C for one edge: the next cycle has stall=0 and rd_data=3C, then in_ready[1] returns to 1.
- Input capture while rd_en is idle: in_ready[0] drops and later in_valid values are ignored until the word is read. The read value is the first word.
- Assert reset with channel 3 full and out_ready=0: out_valid clears immediately, without waiting for a clock edge.
- With IO_OUT_FIFO_EN: four OUTs to channel 0 (11, 22, 33, 44) with no stall. The fifth OUT stalls. Draining delivers 11, 22, 33, 44 in order, and the pointers wrap correctly on a further 6-word burst.

Source files
------------

// File: rtl/io_ctrl.sv
// I/O port controller: four output and four input valid/ready channels serving CPU OUT/IN instructions.
// Define IO_OUT_FIFO_EN to give each output channel a 4-deep FIFO instead of a single holding register.
module io_ctrl #(
  parameter int NPORTS = 4,
  parameter int W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          port_addr,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [W-1:0]        wr_data,
  output logic [W-1:0]        rd_data,
  output logic                stall,
  output logic [NPORTS*W-1:0] out_data,
  output logic [NPORTS-1:0]   out_valid,
  input  logic [NPORTS-1:0]   out_ready,
  input  logic [NPORTS*W-1:0] in_data,
  input  logic [NPORTS-1:0]   in_valid,
  output logic [NPORTS-1:0]   in_ready
);

  logic [NPORTS-1:0] out_stall;
  logic [NPORTS-1:0] in_full;
  logic [W-1:0]      in_hold [NPORTS];

  for (genvar i = 0; i < NPORTS; i++) begin : g_out
    logic sel;
    logic push;
    logic pop;

    assign sel = wr_en && (port_addr == 2'(i));

`ifdef IO_OUT_FIFO_EN
    logic [W-1:0] mem [4];
    logic [1:0]   wp;
    logic [1:0]   rp;
    logic [2:0]   count;

    // A full FIFO still accepts a write when the head word leaves on the same edge.
    assign pop  = (count != 3'd0) && out_ready[i];
    assign push = sel && ((count != 3'd4) || out_ready[i]);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < 4; k++) mem[k] <= '0;
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (push) begin
          mem[wp] <= wr_data;
          wp      <= wp + 2'd1;
        end
        if (pop) rp <= rp + 2'd1;
        count <= count + 3'(push) - 3'(pop);
      end
    end

    assign out_valid[i]         = (count != 3'd0);
    assign out_data[i*W +: W]   = mem[rp];
    assign out_stall[i]         = sel && (count == 3'd4) && !out_ready[i];
`else
    logic         full;
    logic [W-1:0] hold;

    // Pass-through: a full register reloads when the old word is taken on the same edge.
    assign pop  = full && out_ready[i];
    assign push = sel && (!full || out_ready[i]);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        full <= 1'b0;
        hold <= '0;
      end else if (push) begin
        full <= 1'b1;
        hold <= wr_data;
      end else if (pop) begin
        full <= 1'b0;
      end
    end

    assign out_valid[i]         = full;
    assign out_data[i*W +: W]   = hold;
    assign out_stall[i]         = sel && full && !out_ready[i];
`endif
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    logic         full;
    logic [W-1:0] hold;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        full <= 1'b0;
        hold <= '0;
      end else if (in_valid[i] && !full) begin
        full <= 1'b1;
        hold <= in_data[i*W +: W];
      end else if (rd_en && (port_addr == 2'(i)) && full) begin
        full <= 1'b0;
      end
    end

    assign in_ready[i] = !full;
    assign in_full[i]  = full;
    assign in_hold[i]  = hold;
  end

  // An IN to an empty channel stalls and returns zero until a word has been captured.
  always_comb begin
    rd_data = '0;
    stall   = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (rd_en && (port_addr == 2'(i))) begin
        if (in_full[i]) rd_data = in_hold[i];
        else            stall   = 1'b1;
      end
      if (out_stall[i]) stall = 1'b1;
    end
    if (reset) stall = 1'b0;
  end

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: queue-based channel model compared every cycle, plus directed literal checks.
// Build with IO_OUT_FIFO_EN defined to exercise the 4-deep output FIFO scenario as well.
module tb_io_ctrl;

`ifdef IO_OUT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  port_addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_data;
  logic        stall;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;

  int vectors = 0;
  int miscompares = 0;
  bit run_checks = 1'b0;

  logic [7:0] oq [4][$];
  logic [7:0] iq [4][$];

  io_ctrl dut (
    .clk(clk), .reset(reset), .port_addr(port_addr), .wr_en(wr_en), .rd_en(rd_en),
    .wr_data(wr_data), .rd_data(rd_data), .stall(stall), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
    wr_en     = w;
    rd_en     = r;
    port_addr = a;
    wr_data   = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Channel model: each output channel is a queue of at most DEPTH words, each input channel holds at most one.
  always @(posedge clk or posedge reset) begin : model_update
    int osz;
    int isz;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        oq[i].delete();
        iq[i].delete();
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        osz = oq[i].size();
        isz = iq[i].size();
        if (osz != 0 && out_ready[i]) void'(oq[i].pop_front());
        if (wr_en && int'(port_addr) == i && (osz < DEPTH || out_ready[i]))
          oq[i].push_back(wr_data);
        if (rd_en && int'(port_addr) == i && isz != 0) void'(iq[i].pop_front());
        else if (isz == 0 && in_valid[i]) iq[i].push_back(in_data[i*8 +: 8]);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] ev;
    logic [3:0] er;
    logic       es;
    logic [7:0] erd;
    if (run_checks) begin
      ev  = '0;
      er  = '0;
      es  = 1'b0;
      erd = '0;
      for (int i = 0; i < 4; i++) begin
        ev[i] = (oq[i].size() != 0);
        er[i] = (iq[i].size() == 0);
        if (ev[i]) checkOutput($sformatf("out_data%0d", i), 32'(out_data[i*8 +: 8]), 32'(oq[i][0]));
      end
      if (rd_en) begin
        if (iq[port_addr].size() != 0) erd = iq[port_addr][0];
        else es = 1'b1;
      end
      if (wr_en && oq[port_addr].size() == DEPTH && !out_ready[port_addr]) es = 1'b1;
      if (reset) es = 1'b0;
      checkOutput("out_valid", 32'(out_valid), 32'(ev));
      checkOutput("in_ready", 32'(in_ready), 32'(er));
      checkOutput("stall", 32'(stall), 32'(es));
      checkOutput("rd_data", 32'(rd_data), 32'(erd));
    end
  end

  initial begin
    #1 reset = 1'b1;
    #1 run_checks = 1'b1;
    cycle();
    // Reset state, with an IN pending to show stall stays low during reset.
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'hF);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    cycle();
    reset = 1'b0;
    cycle();

    // OUT A5 to channel 2 with the device not ready, then a second OUT that must stall.
    applyStimulus(1'b1, 1'b0, 2'd2, 8'hA5);
    cycle();
    checkOutput("out2_valid", 32'(out_valid), 32'h4);
    checkOutput("out2_data", 32'(out_data[23:16]), 32'hA5);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h5A);
    @(negedge clk);
    checkOutput("out2_stall", 32'(stall), 32'h1);
    cycle();
    out_ready[2] = 1'b1;
    @(negedge clk);
    checkOutput("out2_passthru_stall", 32'(stall), 32'h0);
    cycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    out_ready[2] = 1'b0;
    @(negedge clk);
    checkOutput("out2_second_word", 32'(out_data[23:16]), 32'h5A);
    checkOutput("out2_still_valid", 32'(out_valid), 32'h4);
    out_ready[2] = 1'b1;
    cycle();
    out_ready[2] = 1'b0;
    checkOutput("out2_drained", 32'(out_valid), 32'h0);

    // Back-to-back OUTs to channel 1 with out_ready held high.
    out_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd1, 8'(8'h10 + k));
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    cycle();
    out_ready[1] = 1'b0;

    // IN from empty channel 1, then one-edge capture of 3C.
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    @(negedge clk);
    checkOutput("in1_empty_stall", 32'(stall), 32'h1);
    checkOutput("in1_empty_rd", 32'(rd_data), 32'h0);
    cycle();
    in_valid[1] = 1'b1;
    in_data[15:8] = 8'h3C;
    cycle();
    in_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("in1_stall", 32'(stall), 32'h0);
    checkOutput("in1_rd", 32'(rd_data), 32'h3C);
    checkOutput("in1_ready_low", 32'(in_ready[1]), 32'h0);
    cycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    checkOutput("in1_ready_back", 32'(in_ready[1]), 32'h1);

    // Capture on channel 0 while idle; later offers are ignored until the word is read.
    in_valid[0] = 1'b1;
    in_data[7:0] = 8'h77;
    cycle();
    in_data[7:0] = 8'h88;
    checkOutput("in0_ready_low", 32'(in_ready[0]), 32'h0);
    cycle();
    cycle();
    in_valid[0] = 1'b0;
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h00);
    @(negedge clk);
    checkOutput("in0_first_word", 32'(rd_data), 32'h77);
    cycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    checkOutput("in_all_ready", 32'(in_ready), 32'hF);

    // Asynchronous reset with channel 3 full and not ready.
    applyStimulus(1'b1, 1'b0, 2'd3, 8'h99);
    cycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    checkOutput("out3_valid", 32'(out_valid), 32'h8);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("async_rst_data", out_data, 32'h0);
    cycle();
    reset = 1'b0;
    cycle();

`ifdef IO_OUT_FIFO_EN
    // Fill channel 0, stall on the fifth word, drain in order, then a wrapping burst.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 8'(8'h11 * (k + 1)));
      @(negedge clk);
      checkOutput("fifo_fill_stall", 32'(stall), 32'h0);
      cycle();
    end
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h55);
    @(negedge clk);
    checkOutput("fifo_full_stall", 32'(stall), 32'h1);
    cycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("fifo_drain", 32'(out_data[7:0]), 32'(8'h11 * (k + 1)));
      cycle();
    end
    checkOutput("fifo_empty", 32'(out_valid), 32'h0);
    out_ready[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) out_ready[0] = 1'b1;
      applyStimulus(1'b1, 1'b0, 2'd0, 8'(8'h60 + k));
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    for (int k = 0; k < 6; k++) cycle();
    out_ready[0] = 1'b0;
`endif

    run_checks = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
